prf_wb_arbiter: RTL and testbench

Writeback arbiter between the functional units and the physical register file write ports. It accepts one result per cycle from each of NUM_REQ execute pipes and buffers each in a per-pipe 2-entry FIFO. Each cycle it grants up to NUM_WR_PORTS buffered results, round-robin, and drives them as registered writes onto the register file's execute-side write ports. This lets the core have more functional units than register file write ports without dropping results.

---
 rtl/prf_wb_arbiter_pkg.sv | 17 +
 rtl/prf_wb_arbiter_if.sv | 32 +++
 rtl/wb_fifo2.sv | 48 ++++
 rtl/prf_wb_arbiter.sv | 101 ++++++++++
 tb/tb_prf_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prf_wb_arbiter_pkg.sv
// Shared core parameters and the writeback request type used by the
// writeback arbiter and its per-pipe FIFOs.
//   NUM_FUS      : execute pipes in the core (default requester count)
//   NUM_PREGS    : physical register file depth
//   NUM_WB_PORTS : register file execute-side write ports
//   wb_req_t     : one buffered result {val, dst}
package prf_wb_arbiter_pkg;
  localparam int NUM_FUS      = 4;
  localparam int NUM_PREGS    = 64;
  localparam int NUM_WB_PORTS = 2;
  localparam int PREG_W_DEF   = $clog2(NUM_PREGS);

  typedef struct packed {
    logic [31:0]           val;
    logic [PREG_W_DEF-1:0] dst;
  } wb_req_t;
endpackage

// File: rtl/prf_wb_arbiter_if.sv
// Execute-pipe / register-file writeback bus.
//   flush                      : pipeline flush
//   req_valid/req_val/req_dst  : one result per execute pipe
//   req_ready                  : per-pipe FIFO has room
//   wr_valid/wr_val/wr_dst     : registered register file writes
// master = execute/regfile side, slave = arbiter.
interface prf_wb_arbiter_if
  import prf_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_FUS,
  parameter int NUM_WR_PORTS = NUM_WB_PORTS,
  parameter int PREG_W       = PREG_W_DEF
);
  logic                                flush;
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0][31:0]            req_val;
  logic [NUM_REQ-1:0][PREG_W-1:0]      req_dst;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_WR_PORTS-1:0]             wr_valid;
  logic [NUM_WR_PORTS-1:0][31:0]       wr_val;
  logic [NUM_WR_PORTS-1:0][PREG_W-1:0] wr_dst;

  modport master (
    output flush, req_valid, req_val, req_dst,
    input  req_ready, wr_valid, wr_val, wr_dst
  );

  modport slave (
    input  flush, req_valid, req_val, req_dst,
    output req_ready, wr_valid, wr_val, wr_dst
  );
endinterface

// File: rtl/wb_fifo2.sv
// Two-entry FIFO holding buffered writeback results for one execute pipe.
//   clk, rst (sync, active low), flush : clear all entries
//   push/din : enqueue (ignored when full)
//   pop      : dequeue (ignored when empty)
//   full, empty, head : registered occupancy and oldest entry
module wb_fifo2
  import prf_wb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);
  wb_req_t    mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] cnt;
  logic       do_push, do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  // Full blocks a push even if the same edge pops: ready is based on the
  // registered count only.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      cnt    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/prf_wb_arbiter.sv
// Writeback arbiter: buffers one result per execute pipe per cycle in a
// 2-entry FIFO and grants up to NUM_WR_PORTS heads per cycle round-robin,
// driving them as registered register file writes.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave side of prf_wb_arbiter_if (flush, req_*, wr_*)
module prf_wb_arbiter
  import prf_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_FUS,
  parameter int NUM_WR_PORTS = NUM_WB_PORTS,
  parameter int PREG_W       = PREG_W_DEF
)(
  input logic              clk,
  input logic              rst,
  prf_wb_arbiter_if.slave  bus
);
  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW   = (NUM_WR_PORTS > 1) ? $clog2(NUM_WR_PORTS) : 1;

  logic    [NUM_REQ-1:0] full, empty, push, grant;
  wb_req_t [NUM_REQ-1:0] din, head;

  logic [RR_W-1:0]                   rr_ptr, rr_nxt;
  logic [NUM_WR_PORTS-1:0]           sel_vld;
  logic [NUM_WR_PORTS-1:0][RR_W-1:0] sel_idx;

  logic [NUM_WR_PORTS-1:0]             wr_valid;
  logic [NUM_WR_PORTS-1:0][31:0]       wr_val;
  logic [NUM_WR_PORTS-1:0][PREG_W-1:0] wr_dst;

  // Per-pipe buffering; writes to p0 complete the handshake but are dropped.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign din[i]  = {bus.req_val[i], bus.req_dst[i]};
    assign push[i] = bus.req_valid[i] && !full[i] && (bus.req_dst[i] != '0);

    wb_fifo2 u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush),
      .push  (push[i]),
      .pop   (grant[i]),
      .din   (din[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  assign bus.req_ready = ~full;

  // Round-robin multi-grant: scan from rr_ptr, k-th non-empty FIFO gets port k.
  always_comb begin
    int              ng;
    int              idx;
    logic [RR_W-1:0] idx_r;
    grant   = '0;
    sel_vld = '0;
    sel_idx = '0;
    rr_nxt  = rr_ptr;
    ng      = 0;
    idx     = 0;
    idx_r   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_r = RR_W'(idx);
      if (!empty[idx_r] && ng < NUM_WR_PORTS) begin
        grant[idx_r]        = 1'b1;
        sel_vld[PW'(ng)]    = 1'b1;
        sel_idx[PW'(ng)]    = idx_r;
        ng                  = ng + 1;
        rr_nxt              = (idx == NUM_REQ - 1) ? '0 : RR_W'(idx + 1);
      end
    end
  end

  // Flush keeps rr_ptr and the last data; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr   <= '0;
      wr_valid <= '0;
      wr_val   <= '0;
      wr_dst   <= '0;
    end else if (bus.flush) begin
      wr_valid <= '0;
    end else begin
      wr_valid <= sel_vld;
      rr_ptr   <= rr_nxt;
      for (int j = 0; j < NUM_WR_PORTS; j++) begin
        if (sel_vld[j]) begin
          wr_val[j] <= head[sel_idx[j]].val;
          wr_dst[j] <= head[sel_idx[j]].dst;
        end
      end
    end
  end

  assign bus.wr_valid = wr_valid;
  assign bus.wr_val   = wr_val;
  assign bus.wr_dst   = wr_dst;
endmodule

// File: tb/tb_prf_wb_arbiter.sv
module tb_prf_wb_arbiter;
  import prf_wb_arbiter_pkg::*;
  localparam int NR = NUM_FUS;
  localparam int NW = NUM_WB_PORTS;
  localparam int PW = PREG_W_DEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prf_wb_arbiter_if #(.NUM_REQ(NR), .NUM_WR_PORTS(NW), .PREG_W(PW)) bus ();

  prf_wb_arbiter #(.NUM_REQ(NR), .NUM_WR_PORTS(NW), .PREG_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] q [NR][$];   // expected {val, dst} per requester, in order
  int          stall [NR];
  logic [31:0] rf [64];
  logic [31:0] vctr = 32'd100;

  // Register file model: written one edge after wr_* is presented.
  always @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 64; r++) rf[r] <= '0;
    end else begin
      for (int j = 0; j < NW; j++)
        if (bus.wr_valid[j]) rf[bus.wr_dst[j]] <= bus.wr_val[j];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic [31:0] v, input logic [PW-1:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_val[i]   = v;
    bus.req_dst[i]   = d;
  endtask

  task automatic idle();
    bus.req_valid = '0;
  endtask

  function automatic logic [PW-1:0] dst_of(input logic [31:0] v);
    return PW'((v % 32'd63) + 32'd1);
  endfunction

  function automatic int qsum();
    int s = 0;
    for (int i = 0; i < NR; i++) s += q[i].size();
    return s;
  endfunction

  task automatic monitor();
    logic [NR-1:0] popped;
    logic [NW-1:0] t;
    logic          found;
    popped = '0;
    for (int j = 0; j < NW; j++) begin
      if (bus.wr_valid[j]) begin
        found = 1'b0;
        for (int i = 0; i < NR; i++) begin
          if (!found && q[i].size() > 0 &&
              q[i][0] == {bus.wr_val[j], 32'(bus.wr_dst[j])}) begin
            void'(q[i].pop_front());
            found     = 1'b1;
            popped[i] = 1'b1;
          end
        end
        chk("wr_match", 64'(found), 64'd1);
      end
    end
    t = bus.wr_valid + 1'b1;
    chk("port_pack", 64'(t & bus.wr_valid), 64'd0);
    for (int i = 0; i < NR; i++) begin
      if (q[i].size() > 0 && !popped[i]) begin
        stall[i]++;
        chk("starve", 64'(stall[i] > 2), 64'd0);
      end else begin
        stall[i] = 0;
      end
    end
  endtask

  // Record accepted results, advance one edge, then check outputs.
  task automatic step();
    logic clr;
    clr = !rst || bus.flush;
    if (!clr)
      for (int i = 0; i < NR; i++)
        if (bus.req_valid[i] && bus.req_ready[i] && bus.req_dst[i] != '0)
          q[i].push_back({bus.req_val[i], 32'(bus.req_dst[i])});
    @(posedge clk);
    #1;
    if (clr) begin
      for (int i = 0; i < NR; i++) begin
        q[i].delete();
        stall[i] = 0;
      end
      chk("clr_wr_valid", 64'(bus.wr_valid), 64'd0);
    end else begin
      monitor();
    end
  endtask

  initial begin
    logic          seen_drop;
    logic [NR-1:0] acc;
    bus.flush   = 1'b0;
    bus.req_valid = '0;
    bus.req_val = '0;
    bus.req_dst = '0;
    for (int i = 0; i < NR; i++) stall[i] = 0;

    // Reset state
    rst = 1'b0;
    step();
    step();
    chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    chk("rst_wr_val",   64'(bus.wr_val),   64'd0);
    chk("rst_wr_dst",   64'(bus.wr_dst),   64'd0);
    chk("rst_ready",    64'(bus.req_ready), 64'hF);
    rst = 1'b1;
    step();

    // Single write: two edges from accept to wr_*
    drive(0, 32'd12, PW'(7));
    step();
    idle();
    chk("sw_early", 64'(bus.wr_valid), 64'd0);
    step();
    chk("sw_vld", 64'(bus.wr_valid), 64'b01);
    chk("sw_val", 64'(bus.wr_val[0]), 64'd12);
    chk("sw_dst", 64'(bus.wr_dst[0]), 64'd7);
    step();
    chk("sw_done", 64'(bus.wr_valid), 64'd0);
    chk("sw_rf7", 64'(rf[7]), 64'd12);

    // Reset so the oversubscription scan starts at requester 0
    rst = 1'b0;
    step();
    rst = 1'b1;

    // Oversubscription: 4 pushes, 2 ports
    for (int i = 0; i < NR; i++) drive(i, 32'(10 + i), PW'(i + 1));
    step();
    idle();
    step();
    chk("os1_vld",  64'(bus.wr_valid), 64'b11);
    chk("os1_dst0", 64'(bus.wr_dst[0]), 64'd1);
    chk("os1_dst1", 64'(bus.wr_dst[1]), 64'd2);
    chk("os1_val0", 64'(bus.wr_val[0]), 64'd10);
    chk("os1_val1", 64'(bus.wr_val[1]), 64'd11);
    step();
    chk("os2_vld",  64'(bus.wr_valid), 64'b11);
    chk("os2_dst0", 64'(bus.wr_dst[0]), 64'd3);
    chk("os2_dst1", 64'(bus.wr_dst[1]), 64'd4);
    chk("os2_val1", 64'(bus.wr_val[1]), 64'd13);
    chk("os_rr",    64'(dut.rr_ptr), 64'd0);
    step();
    chk("os_done", 64'(bus.wr_valid), 64'd0);
    chk("os_left", 64'(qsum()), 64'd0);

    // p0 filter
    drive(2, 32'd99, PW'(0));
    chk("p0_ready", 64'(bus.req_ready), 64'hF);
    step();
    idle();
    chk("p0_ready_after", 64'(bus.req_ready), 64'hF);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("p0_no_wr", 64'(bus.wr_valid), 64'd0);
    end
    chk("p0_rf0", 64'(rf[0]), 64'd0);

    // Backpressure: pipe 1 holds valid 4 cycles, others stream 8 cycles
    seen_drop = 1'b0;
    for (int i = 0; i < NR; i++) begin
      drive(i, vctr, dst_of(vctr));
      vctr++;
    end
    for (int c = 0; c < 8; c++) begin
      acc = bus.req_valid & bus.req_ready;
      step();
      if (!bus.req_ready[1]) seen_drop = 1'b1;
      for (int i = 0; i < NR; i++) begin
        if (i == 1 && c >= 3) bus.req_valid[1] = 1'b0;
        else if (acc[i]) begin
          drive(i, vctr, dst_of(vctr));
          vctr++;
        end
      end
    end
    idle();
    for (int c = 0; c < 6; c++) step();
    chk("bp_drop",  64'(seen_drop), 64'd1);
    chk("bp_drain", 64'(qsum()), 64'd0);
    chk("bp_ready", 64'(bus.req_ready), 64'hF);

    // Flush: fill FIFOs, then one-cycle flush
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NR; i++) begin
        drive(i, vctr, dst_of(vctr));
        vctr++;
      end
      step();
    end
    chk("fl_full", 64'(bus.req_ready != 4'hF), 64'd1);
    idle();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl_ready", 64'(bus.req_ready), 64'hF);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("fl_no_wr", 64'(bus.wr_valid), 64'd0);
    end

    // Reset mid-stream
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NR; i++) begin
        drive(i, vctr, dst_of(vctr));
        vctr++;
      end
      rst = (c >= 2) ? 1'b0 : 1'b1;
      step();
      if (c >= 2) begin
        chk("mr_wr_val", 64'(bus.wr_val), 64'd0);
        chk("mr_wr_dst", 64'(bus.wr_dst), 64'd0);
        chk("mr_ready",  64'(bus.req_ready), 64'hF);
      end
    end
    rst = 1'b1;
    idle();
    step();
    chk("mr_post_vld",   64'(bus.wr_valid), 64'd0);
    chk("mr_post_ready", 64'(bus.req_ready), 64'hF);
    drive(0, 32'd501, PW'(11));
    drive(1, 32'd502, PW'(12));
    drive(2, 32'd503, PW'(13));
    step();
    idle();
    step();
    chk("mr_g_vld",  64'(bus.wr_valid), 64'b11);
    chk("mr_g_dst0", 64'(bus.wr_dst[0]), 64'd11);
    chk("mr_g_dst1", 64'(bus.wr_dst[1]), 64'd12);
    step();
    chk("mr_g2_vld",  64'(bus.wr_valid), 64'b01);
    chk("mr_g2_dst0", 64'(bus.wr_dst[0]), 64'd13);
    step();
    chk("mr_left", 64'(qsum()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
